// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: single-issue MULT/MULTU/DIV/DIVU/MTHI/MTLO with a
// radix-2 restoring divider and architectural HI/LO written at the end of WB.
module hilo_muldiv_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  input  logic              req_cancel,
  output logic              done,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy
);

  localparam int unsigned CNT_W    = $clog2(DATA_W + 1);
  localparam int unsigned PROD_W   = 2 * DATA_W;
  localparam int unsigned MUL_LAST = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;
  localparam int unsigned DIV_LAST = DATA_W - 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_WB} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d, quot_q, quot_d;
  logic [DATA_W-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d, busy_q, busy_d, ready_q, ready_d;

  logic              accept;
  logic              is_signed;
  logic [2:0]        op_sel;
  logic [DATA_W-1:0] a_sel, b_sel, dvs;
  logic [DATA_W:0]   a_ext, b_ext, rem_sh, trial;
  logic [PROD_W-1:0] prod;
  logic [DATA_W-1:0] rem_n, quot_n;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic sgn);
    return (sgn && x[DATA_W-1]) ? (~x + DATA_W'(1)) : x;
  endfunction

  // Operands come straight from the request in IDLE so single-cycle ops can finish in WB.
  always_comb begin
    accept    = (state_q == S_IDLE) && req_valid && !flush;
    op_sel    = (state_q == S_IDLE) ? req_op   : op_q;
    a_sel     = (state_q == S_IDLE) ? req_src1 : src1_q;
    b_sel     = (state_q == S_IDLE) ? req_src2 : src2_q;
    is_signed = ~op_sel[0];
    a_ext     = {is_signed & a_sel[DATA_W-1], a_sel};
    b_ext     = {is_signed & b_sel[DATA_W-1], b_sel};
    prod      = PROD_W'($signed(a_ext)) * PROD_W'($signed(b_ext));
    dvs       = mag(src2_q, ~op_q[0]);
    rem_sh    = {rem_q, quot_q[DATA_W-1]};
    trial     = rem_sh - {1'b0, dvs};
    rem_n     = trial[DATA_W] ? rem_sh[DATA_W-1:0] : trial[DATA_W-1:0];
    quot_n    = {quot_q[DATA_W-2:0], ~trial[DATA_W]};
  end

  // Next-state, datapath and architectural-register update.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = req_op;
          src1_d = req_src1;
          src2_d = req_src2;
          cnt_d  = '0;
          rem_d  = '0;
          quot_d = mag(req_src1, ~req_op[0]);
          case (req_op)
            OP_MULT, OP_MULTU: begin
              if (MUL_LAT == 1) begin
                state_d  = S_WB;
                res_hi_d = prod[PROD_W-1:DATA_W];
                res_lo_d = prod[DATA_W-1:0];
              end else begin
                state_d = S_MUL;
              end
            end
            OP_DIV, OP_DIVU: state_d = S_DIV;
            default: begin
              state_d  = S_WB;
              res_hi_d = (req_op == OP_MTHI) ? req_src1 : '0;
              res_lo_d = (req_op == OP_MTLO) ? req_src1 : '0;
            end
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == CNT_W'(MUL_LAST)) begin
          state_d  = S_WB;
          res_hi_d = prod[PROD_W-1:DATA_W];
          res_lo_d = prod[DATA_W-1:0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DIV: begin
        rem_d  = rem_n;
        quot_d = quot_n;
        if (cnt_q == CNT_W'(DIV_LAST)) begin
          state_d  = S_WB;
          res_lo_d = mag(quot_n, 1'b0);
          res_hi_d = rem_n;
          if (!op_q[0] && (src1_q[DATA_W-1] ^ src2_q[DATA_W-1])) res_lo_d = ~quot_n + DATA_W'(1);
          if (!op_q[0] && src1_q[DATA_W-1]) res_hi_d = ~rem_n + DATA_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        if (!req_cancel && !flush) begin
          if (op_q <= OP_MTHI) hi_d = res_hi_q;
          if (op_q <= OP_DIVU || op_q == OP_MTLO) lo_d = res_lo_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush kills whatever is in flight, including a result about to be produced.
    if (flush) begin
      state_d  = S_IDLE;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
    end

    done_d  = (state_d == S_WB);
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign res_hi    = res_hi_q;
  assign res_lo    = res_lo_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit (DATA_W=32, MUL_LAT=2): vector table plus
// flush, cancel and mid-divide reset sequences.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, flush, req_valid, req_ready, req_cancel;
  logic [2:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        done, busy;
  logic [31:0] res_hi, res_lo, hi, lo;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.DATA_W(32), .MUL_LAT(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_cancel(req_cancel),
    .done(done), .res_hi(res_hi), .res_lo(res_lo),
    .hi(hi), .lo(lo), .busy(busy)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          lat;
    bit          chk_res;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op, measure latency to done, check result and the HI/LO update after WB.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [31:0] ehi, input logic [31:0] elo,
                        input int lat, input bit chk_res);
    int cyc;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_src1 = s1; req_src2 = s2;
    @(negedge clk);
    req_valid = 1'b0;
    check({name, " busy"}, 32'(busy), 32'd1);
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'(lat));
    if (chk_res) begin
      check({name, " res_hi"}, res_hi, ehi);
      check({name, " res_lo"}, res_lo, elo);
    end
    if (op <= 3'd4) m_hi = ehi;
    if (op <= 3'd3 || op == 3'd5) m_lo = elo;
    @(negedge clk);
    check({name, " hi"}, hi, m_hi);
    check({name, " lo"}, lo, m_lo);
    check({name, " ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{"mult_neg1x2",  3'd0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 2,  1'b1};
    vecs[1]  = '{"multu_ffx2",   3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 2,  1'b1};
    vecs[2]  = '{"div_m7_2",     3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b1};
    vecs[3]  = '{"divu_7_0",     3'd3, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 33, 1'b1};
    vecs[4]  = '{"div_min_m1",   3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b1};
    vecs[5]  = '{"mthi",         3'd4, 32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 1,  1'b1};
    vecs[6]  = '{"mtlo",         3'd5, 32'hCAFEF00D, 32'h0,        32'h00000000, 32'hCAFEF00D, 1,  1'b1};
    vecs[7]  = '{"divu_100_7",   3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       33, 1'b1};
    vecs[8]  = '{"div_100_m7",   3'd2, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 33, 1'b1};
    vecs[9]  = '{"mult_min_min", 3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 2,  1'b1};
    vecs[10] = '{"multu_ff_ff",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2,  1'b1};
    vecs[11] = '{"reserved6",    3'd6, 32'h11111111, 32'h22222222, 32'h0,        32'h0,        1,  1'b0};
    vecs[12] = '{"div_m7_0",     3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'h00000001, 33, 1'b1};

    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_cancel = 1'b0;
    req_op = '0; req_src1 = '0; req_src2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst busy",  32'(busy), 32'd0);
    check("rst done",  32'(done), 32'd0);
    check("rst ready", 32'(req_ready), 32'd1);
    check("rst hi",    hi, 32'd0);
    check("rst lo",    lo, 32'd0);

    for (int i = 0; i < 13; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].s1, vecs[i].s2,
             vecs[i].ehi, vecs[i].elo, vecs[i].lat, vecs[i].chk_res);

    // MTHI with cancel in WB: done still pulses, HI untouched.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd4; req_src1 = 32'hDEADBEEF;
    @(negedge clk);
    req_valid = 1'b0;
    check("cancel done", 32'(done), 32'd1);
    check("cancel res_hi", res_hi, 32'hDEADBEEF);
    req_cancel = 1'b1;
    @(negedge clk);
    req_cancel = 1'b0;
    check("cancel hi", hi, m_hi);
    check("cancel done_after", 32'(done), 32'd0);

    // Flush on the 10th DIV cycle, then a new request right away.
    begin
      int seen_done;
      seen_done = 0;
      req_valid = 1'b1; req_op = 3'd3; req_src1 = 32'd100; req_src2 = 32'd7;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
        if (done) seen_done++;
        @(negedge clk);
      end
      if (done) seen_done++;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush no_done_before", 32'(seen_done), 32'd0);
      check("flush busy",  32'(busy), 32'd0);
      check("flush done",  32'(done), 32'd0);
      check("flush ready", 32'(req_ready), 32'd1);
      check("flush hi", hi, m_hi);
      check("flush lo", lo, m_lo);
      req_valid = 1'b1; req_op = 3'd5; req_src1 = 32'h0BADF00D;
      @(negedge clk);
      req_valid = 1'b0;
      check("post_flush done", 32'(done), 32'd1);
      check("post_flush res_lo", res_lo, 32'h0BADF00D);
      m_lo = 32'h0BADF00D;
      @(negedge clk);
      check("post_flush lo", lo, m_lo);
    end

    // Reset in the middle of a divide.
    run_op("seed_hi", 3'd4, 32'h55555555, 32'h0, 32'h55555555, 32'h0, 1, 1'b1);
    run_op("seed_lo", 3'd5, 32'h55555555, 32'h0, 32'h0, 32'h55555555, 1, 1'b1);
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd2; req_src1 = 32'd1000; req_src2 = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1; flush = 1'b1; req_valid = 1'b1; req_op = 3'd4; req_src1 = 32'hFFFFFFFF;
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; req_valid = 1'b0;
    m_hi = '0; m_lo = '0;
    check("midrst hi", hi, m_hi);
    check("midrst lo", lo, m_lo);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst ready", 32'(req_ready), 32'd1);
    check("midrst done", 32'(done), 32'd0);
    check("midrst res_hi", res_hi, 32'd0);
    check("midrst res_lo", res_lo, 32'd0);
    @(negedge clk);
    check("midrst done_after", 32'(done), 32'd0);
    check("midrst busy_after", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
